// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI transmitter pixel path.
// Frame geometry, pixel/SRAM widths and the pixel-fetch FSM state encoding.
package hdmi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int FRAME_PIXELS = 307200;
  localparam int PIXEL_W      = 24;
  localparam int SRAM_DW      = 16;
  localparam int PIX_ADDR_W   = 20;

endpackage

// File: rtl/flex_counter.sv
// Wait-state counter: counts enabled cycles from 0 up to rollover_val, then wraps to 0.
// rollover_flag is combinational and is high while the count sits at rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = '0;
      else                         count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/sram_pixel_fetch.sv
// Fetches one 24-bit pixel as two 16-bit SRAM words; data_ready pulses 2*(WAIT_STATES+1)+1 cycles after a request.
// One request can wait in a pending slot while busy; further requests are dropped and flagged in req_overflow.
module sram_pixel_fetch
  import hdmi_pkg::*;
#(
  parameter int WAIT_STATES  = 1,
  parameter int FRAME_PIXELS = hdmi_pkg::FRAME_PIXELS
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        read_request,
  input  logic [19:0] address_line,
  input  logic [15:0] sram_data,
  output logic [20:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic [23:0] data_line,
  output logic        data_ready,
  output logic        frame_done,
  output logic        busy,
  output logic        req_overflow
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  fetch_state_e                  state_q, state_d;
  logic [PIX_ADDR_W-1:0]         cur_addr_q, cur_addr_d;
  logic                          slot_vld_q, slot_vld_d;
  logic [PIX_ADDR_W-1:0]         slot_addr_q, slot_addr_d;
  logic [SRAM_DW-1:0]            pixel_lo_q, pixel_lo_d;
  logic [PIXEL_W-1:0]            data_line_q, data_line_d;
  logic                          overflow_q, overflow_d;

  logic                          reading;
  logic                          cnt_clear;
  logic                          wait_done;
  logic [CNT_W-1:0]              cnt_value;

  assign reading = (state_q == RD_LO) || (state_q == RD_HI);

  // Restart the wait-state count whenever a word read begins, including DONE -> RD_LO.
  assign cnt_clear = (state_d != state_q) && ((state_d == RD_LO) || (state_d == RD_HI));

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_wait_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (reading),
    .rollover_val  (CNT_W'(WAIT_STATES)),
    .count_out     (cnt_value),
    .rollover_flag (wait_done)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    pixel_lo_d  = pixel_lo_q;
    data_line_d = data_line_q;
    overflow_d  = overflow_q;

    if (reading && read_request) begin
      if (!slot_vld_q) begin
        slot_vld_d  = 1'b1;
        slot_addr_d = address_line;
      end else begin
        overflow_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (read_request) begin
          cur_addr_d = address_line;
          state_d    = RD_LO;
        end
      end
      RD_LO: begin
        if (wait_done) begin
          pixel_lo_d = sram_data;
          state_d    = RD_HI;
        end
      end
      RD_HI: begin
        if (wait_done) begin
          data_line_d = {sram_data[7:0], pixel_lo_q};
          state_d     = DONE;
        end
      end
      DONE: begin
        // The slot is freed as it is consumed, so a request this cycle refills it.
        if (slot_vld_q) begin
          cur_addr_d  = slot_addr_q;
          slot_vld_d  = read_request;
          slot_addr_d = read_request ? address_line : slot_addr_q;
          state_d     = RD_LO;
        end else if (read_request) begin
          cur_addr_d = address_line;
          state_d    = RD_LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      pixel_lo_q  <= '0;
      data_line_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      pixel_lo_q  <= pixel_lo_d;
      data_line_q <= data_line_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sram_addr    = reading ? {cur_addr_q, (state_q == RD_HI)} : '0;
  assign sram_ce_n    = !reading;
  assign sram_oe_n    = !reading;
  assign data_line    = data_line_q;
  assign data_ready   = (state_q == DONE);
  assign frame_done   = (state_q == DONE) && (cur_addr_q[18:0] == 19'(FRAME_PIXELS - 1));
  assign busy         = (state_q != IDLE);
  assign req_overflow = overflow_q;

  // The upper byte of the high word carries no pixel data.
  logic unused_bits;
  assign unused_bits = ^{sram_data[15:8], cnt_value};

endmodule

// File: tb/tb_sram_pixel_fetch.sv
// Directed plus randomized checks of sram_pixel_fetch against a transaction-level model.
// SRAM contents come from a keyed address function shared by the bench's SRAM and its model.
module tb_sram_pixel_fetch;

  localparam int LAT   = 2 * (1 + 1) + 1;
  localparam int LAT3  = 2 * (3 + 1) + 1;
  localparam int LAST  = 307200 - 1;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        read_request;
  logic [19:0] address_line;
  logic [15:0] sram_data;
  logic [20:0] sram_addr;
  logic        sram_ce_n, sram_oe_n;
  logic [23:0] data_line;
  logic        data_ready, frame_done, busy, req_overflow;

  logic        read_request3;
  logic [19:0] address_line3;
  logic [15:0] sram_data3;
  logic [20:0] sram_addr3;
  logic        sram_ce_n3, sram_oe_n3;
  logic [23:0] data_line3;
  logic        data_ready3, frame_done3, busy3, req_overflow3;

  logic [15:0] key;
  int          checks = 0;
  int          errors = 0;

  int          req_n[$];
  logic [19:0] req_a[$];
  int          rdy_n[$];
  logic [23:0] rdy_d[$];
  logic        rdy_f[$];
  logic        ce_log   [0:63];
  logic [20:0] addr_log [0:63];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [20:0] a, input logic [15:0] k);
    if (a == 21'h0000A) return 16'h3344;
    if (a == 21'h0000B) return 16'h0011;
    return a[15:0] ^ {a[20:16], a[20:10]} ^ k;
  endfunction

  function automatic logic [23:0] exp_pixel(input logic [19:0] a);
    logic [15:0] lo, hi;
    lo = mem_word({a, 1'b0}, key);
    hi = mem_word({a, 1'b1}, key);
    return {hi[7:0], lo};
  endfunction

  assign sram_data  = mem_word(sram_addr, key);
  assign sram_data3 = mem_word(sram_addr3, key);

  sram_pixel_fetch dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .read_request (read_request),
    .address_line (address_line),
    .sram_data    (sram_data),
    .sram_addr    (sram_addr),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .data_line    (data_line),
    .data_ready   (data_ready),
    .frame_done   (frame_done),
    .busy         (busy),
    .req_overflow (req_overflow)
  );

  sram_pixel_fetch #(.WAIT_STATES(3)) dut3 (
    .clk          (clk),
    .n_rst        (n_rst),
    .read_request (read_request3),
    .address_line (address_line3),
    .sram_data    (sram_data3),
    .sram_addr    (sram_addr3),
    .sram_ce_n    (sram_ce_n3),
    .sram_oe_n    (sram_oe_n3),
    .data_line    (data_line3),
    .data_ready   (data_ready3),
    .frame_done   (frame_done3),
    .busy         (busy3),
    .req_overflow (req_overflow3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives queued requests (window index, address) and logs outputs per window.
  task automatic run(input int ncyc);
    rdy_n.delete();
    rdy_d.delete();
    rdy_f.delete();
    for (int n = 0; n < ncyc; n++) begin
      read_request = 1'b0;
      foreach (req_n[i]) begin
        if (req_n[i] == n) begin
          read_request = 1'b1;
          address_line = req_a[i];
        end
      end
      if (data_ready) begin
        rdy_n.push_back(n);
        rdy_d.push_back(data_line);
        rdy_f.push_back(frame_done);
      end
      if (n < 64) begin
        ce_log[n]   = sram_ce_n;
        addr_log[n] = sram_addr;
      end
      tick();
    end
    read_request = 1'b0;
    req_n.delete();
    req_a.delete();
  endtask

  function automatic int pulse_at(input int i);
    return (rdy_n.size() > i) ? rdy_n[i] : -1;
  endfunction

  function automatic logic [23:0] data_at(input int i);
    return (rdy_d.size() > i) ? rdy_d[i] : 24'hxxxxxx;
  endfunction

  function automatic logic frame_at(input int i);
    return (rdy_f.size() > i) ? rdy_f[i] : 1'bx;
  endfunction

  task automatic single(input string tag, input logic [19:0] a);
    req_n.push_back(0);
    req_a.push_back(a);
    run(12);
    chk({tag, "_npulse"}, rdy_n.size(), 1);
    chk({tag, "_lat"}, pulse_at(0), LAT);
    chk({tag, "_data"}, data_at(0), exp_pixel(a));
    chk({tag, "_frame"}, frame_at(0), (a[18:0] == 19'(LAST)));
    chk({tag, "_addr_lo"}, addr_log[1], {a, 1'b0});
    chk({tag, "_addr_hi"}, addr_log[3], {a, 1'b1});
    chk({tag, "_ce_rd"}, {ce_log[1], ce_log[2], ce_log[3], ce_log[4]}, 4'b0000);
    chk({tag, "_ce_done"}, ce_log[5], 1'b1);
  endtask

  task automatic pair(input string tag, input logic [19:0] a, input logic [19:0] b, input int d);
    req_n.push_back(0);
    req_a.push_back(a);
    req_n.push_back(d);
    req_a.push_back(b);
    run(20);
    chk({tag, "_npulse"}, rdy_n.size(), 2);
    chk({tag, "_t0"}, pulse_at(0), LAT);
    chk({tag, "_t1"}, pulse_at(1), 2 * LAT);
    chk({tag, "_d0"}, data_at(0), exp_pixel(a));
    chk({tag, "_d1"}, data_at(1), exp_pixel(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] a, b, c;
    logic [23:0] held;
    int          ce3, oe3, t3;
    logic [23:0] d3;

    key           = 16'($urandom);
    n_rst         = 1'b0;
    read_request  = 1'b0;
    address_line  = '0;
    read_request3 = 1'b0;
    address_line3 = '0;
    #12;
    chk("rst_sram_addr", sram_addr, 21'h0);
    chk("rst_ce_oe", {sram_ce_n, sram_oe_n}, 2'b11);
    chk("rst_data_line", data_line, 24'h0);
    chk("rst_pulses", {data_ready, frame_done}, 2'b00);
    chk("rst_busy_ovf", {busy, req_overflow}, 2'b00);
    chk("rst3_state", {sram_ce_n3, busy3, data_ready3, req_overflow3}, 4'b1000);
    n_rst = 1'b1;
    tick();

    // Known SRAM words give the documented pixel.
    single("t1", 20'h00005);
    chk("t1_const", data_at(0), 24'h113344);
    held = data_line;
    run(4);
    chk("t1_held", data_line, held);
    chk("t1_idle", busy, 1'b0);

    // Last pixel of a frame.
    single("t2", 20'h4AFFF);
    chk("t2_lo_const", addr_log[1], 21'h095FFE);
    chk("t2_hi_const", addr_log[3], 21'h095FFF);

    // Three requests on consecutive cycles: third is dropped.
    a = 20'h12345; b = 20'h0ABCD; c = 20'hFEDCB;
    req_n = '{0, 1, 2};
    req_a = '{a, b, c};
    run(25);
    chk("t3_npulse", rdy_n.size(), 2);
    chk("t3_t0", pulse_at(0), LAT);
    chk("t3_t1", pulse_at(1), 2 * LAT);
    chk("t3_d0", data_at(0), exp_pixel(a));
    chk("t3_d1", data_at(1), exp_pixel(b));
    chk("t3_ovf", req_overflow, 1'b1);
    run(10);
    chk("t3_ovf_sticky", req_overflow, 1'b1);
    chk("t3_no_third", rdy_n.size(), 0);

    // Request during DONE goes straight back to RD_LO.
    a = 20'h00777; b = 20'h81234;
    pair("t4", a, b, LAT);
    chk("t4_ce_next", ce_log[LAT + 1], 1'b0);
    chk("t4_addr_next", addr_log[LAT + 1], {b, 1'b0});

    // Reset while reading the high word, with the pending slot full.
    a = 20'h0F0F0; b = 20'h01111; c = 20'h02222;
    held = data_line;
    read_request = 1'b1; address_line = a;
    tick();
    read_request = 1'b1; address_line = b;
    tick();
    read_request = 1'b0;
    tick();
    chk("t5_in_rd_hi", {sram_ce_n, sram_oe_n, sram_addr}, {2'b00, a, 1'b1});
    n_rst = 1'b0;
    #1;
    chk("t5_rst_ce_oe", {sram_ce_n, sram_oe_n}, 2'b11);
    chk("t5_rst_addr", sram_addr, 21'h0);
    chk("t5_rst_misc", {busy, data_ready, frame_done, req_overflow}, 4'b0000);
    chk("t5_rst_data", data_line, 24'h0);
    tick();
    tick();
    n_rst = 1'b1;
    run(15);
    chk("t5_slot_dropped", rdy_n.size(), 0);
    chk("t5_data_untouched", data_line, 24'h0);
    single("t5_after", c);

    // Random single fetches, some landing on the last pixel of a frame.
    for (int i = 0; i < 12; i++) begin
      a[19]   = 1'($urandom);
      a[18:0] = (i % 4 == 0) ? 19'(LAST) : 19'($urandom_range(0, LAST));
      single($sformatf("rs%0d", i), a);
      run($urandom_range(0, 2));
    end

    // Random pairs: second request arrives at any point up to the first DONE.
    for (int i = 0; i < 6; i++) begin
      a = 20'($urandom);
      b = 20'($urandom);
      pair($sformatf("rp%0d", i), a, b, $urandom_range(1, LAT));
    end

    // Three wait states on the second instance.
    a = 20'($urandom);
    ce3 = 0; oe3 = 0; t3 = -1; d3 = '0;
    for (int n = 0; n < 20; n++) begin
      read_request3 = (n == 0);
      address_line3 = a;
      if (!sram_ce_n3) ce3++;
      if (!sram_oe_n3) oe3++;
      if (data_ready3 && t3 < 0) begin
        t3 = n;
        d3 = data_line3;
      end
      tick();
    end
    read_request3 = 1'b0;
    chk("ws3_lat", t3, LAT3);
    chk("ws3_ce_cycles", ce3, 8);
    chk("ws3_oe_cycles", oe3, 8);
    chk("ws3_data", d3, exp_pixel(a));
    chk("ws3_end", {busy3, frame_done3, req_overflow3}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
